// File: rtl/lwc_pkg.sv
// Shared opcodes, segment types, header flag positions and FSM encoding for the LWC pre-processor.
package lwc_pkg;

   localparam logic [3:0] OP_ENC    = 4'b0010;
   localparam logic [3:0] OP_DEC    = 4'b0011;
   localparam logic [3:0] OP_ACTKEY = 4'b0111;
   localparam logic [3:0] OP_LDKEY  = 4'b0100;

   localparam logic [3:0] T_AD   = 4'b0001;
   localparam logic [3:0] T_PT   = 4'b0100;
   localparam logic [3:0] T_CT   = 4'b0101;
   localparam logic [3:0] T_TAG  = 4'b1000;
   localparam logic [3:0] T_KEY  = 4'b1100;
   localparam logic [3:0] T_NPUB = 4'b1101;

   localparam int HDR_EOI  = 26;
   localparam int HDR_EOT  = 25;
   localparam int HDR_LAST = 24;

   typedef enum logic [2:0] {
      S_INST,
      S_KINST,
      S_KHDR,
      S_KDATA,
      S_HDR,
      S_DATA,
      S_ZERO
   } state_t;

   // Keeps the first 'size' bytes of a word, MSB first.
   function automatic logic [31:0] byte_mask(input logic [2:0] size);
      case (size)
         3'd0:    return 32'h0000_0000;
         3'd1:    return 32'hFF00_0000;
         3'd2:    return 32'hFFFF_0000;
         3'd3:    return 32'hFFFF_FF00;
         default: return 32'hFFFF_FFFF;
      endcase
   endfunction

endpackage

// File: rtl/lwc_seg_ctr.sv
// Remaining-byte counter for one data segment; derives the current beat size and last-beat flag.
// Size and last flag are combinational from the registered count; the count updates on each transfer.
module lwc_seg_ctr (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [15:0] len,
   input  logic        dec,
   output logic [2:0]  bdi_size,
   output logic        is_last
);

   logic [15:0] remaining;

   always_ff @(posedge clk) begin
      if (rst) begin
         remaining <= 16'd0;
      end else if (load) begin
         remaining <= len;
      end else if (dec) begin
         remaining <= remaining - {13'd0, bdi_size};
      end
   end

   assign bdi_size = (remaining >= 16'd4) ? 3'd4 : remaining[2:0];
   assign is_last  = (remaining <= 16'd4);

endmodule

// File: rtl/lwc_pre_processor.sv
// LWC input formatter: parses pdi/sdi instructions and headers, passes data beats through with zero latency.
// Optional LWC_PROTOCOL_CHECK_EN flags illegal opcodes/header types on err; back-pressure passes straight through.
module lwc_pre_processor
   import lwc_pkg::*;
#(
   parameter int PW         = 32,
   parameter int SW         = 32,
   parameter int G_KEY_SIZE = 128
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [PW-1:0] pdi_data,
   input  logic          pdi_valid,
   output logic          pdi_ready,
   input  logic [SW-1:0] sdi_data,
   input  logic          sdi_valid,
   output logic          sdi_ready,
   output logic [SW-1:0] key,
   output logic          key_valid,
   input  logic          key_ready,
   output logic          key_update,
   output logic [PW-1:0] bdi,
   output logic          bdi_valid,
   input  logic          bdi_ready,
   output logic [3:0]    bdi_type,
   output logic [2:0]    bdi_size,
   output logic          bdi_eot,
   output logic          bdi_eoi,
   output logic          decrypt,
   output logic          err
);

   localparam int KW  = G_KEY_SIZE / SW;
   localparam int KCW = $clog2(KW + 1);

   state_t         state;
   logic [KCW-1:0] kcnt;
   logic           flg_eoi, flg_eot, flg_last;
   logic [2:0]     seg_size;
   logic           seg_last;
   logic           pdi_fire, sdi_fire, bdi_fire;
   logic           inst_bad, kinst_bad, hdr_bad;
   logic [3:0]     op;

   assign op       = pdi_data[PW-1 -: 4];
   assign pdi_fire = pdi_valid && pdi_ready;
   assign sdi_fire = sdi_valid && sdi_ready;
   assign bdi_fire = bdi_valid && bdi_ready;

   lwc_seg_ctr u_seg_ctr (
      .clk      (clk),
      .rst      (rst),
      .load     ((state == S_HDR) && pdi_fire && !hdr_bad),
      .len      (pdi_data[15:0]),
      .dec      ((state == S_DATA) && bdi_fire),
      .bdi_size (seg_size),
      .is_last  (seg_last)
   );

`ifdef LWC_PROTOCOL_CHECK_EN
   logic err_q;

   assign inst_bad  = !(op == OP_ENC || op == OP_DEC || op == OP_ACTKEY);
   assign kinst_bad = (sdi_data[SW-1 -: 4] != OP_LDKEY);
   assign hdr_bad   = (op == 4'b0000) || (op == 4'b1111);

   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= ((state == S_INST)  && pdi_fire && inst_bad)  ||
                  ((state == S_KINST) && sdi_fire && kinst_bad) ||
                  ((state == S_HDR)   && pdi_fire && hdr_bad);
      end
   end

   assign err = err_q;
`else
   assign inst_bad  = 1'b0;
   assign kinst_bad = 1'b0;
   assign hdr_bad   = 1'b0;
   assign err       = 1'b0;
`endif

   // Handshakes are gated off during reset so every output reads 0.
   always_comb begin
      pdi_ready = 1'b0;
      sdi_ready = 1'b0;
      key       = '0;
      key_valid = 1'b0;
      bdi       = '0;
      bdi_valid = 1'b0;
      bdi_size  = 3'd0;
      bdi_eot   = 1'b0;
      bdi_eoi   = 1'b0;
      if (!rst) begin
         case (state)
            S_INST, S_HDR: pdi_ready = 1'b1;
            S_KINST, S_KHDR: sdi_ready = 1'b1;
            S_KDATA: begin
               key       = sdi_data;
               key_valid = sdi_valid;
               sdi_ready = key_ready;
            end
            S_DATA: begin
               bdi_valid = pdi_valid;
               pdi_ready = bdi_ready;
               bdi_size  = seg_size;
               bdi       = pdi_data & byte_mask(seg_size);
               bdi_eot   = seg_last && flg_eot;
               bdi_eoi   = seg_last && flg_eoi;
            end
            S_ZERO: begin
               bdi_valid = 1'b1;
               bdi_eot   = flg_eot;
               bdi_eoi   = flg_eoi;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_INST;
         kcnt       <= '0;
         key_update <= 1'b0;
         decrypt    <= 1'b0;
         bdi_type   <= 4'd0;
         flg_eoi    <= 1'b0;
         flg_eot    <= 1'b0;
         flg_last   <= 1'b0;
      end else begin
         key_update <= 1'b0;
         case (state)
            S_INST: begin
               if (pdi_fire && !inst_bad) begin
                  if (op == OP_ACTKEY) begin
                     key_update <= 1'b1;
                     state      <= S_KINST;
                  end else begin
                     decrypt <= op[0];
                     state   <= S_HDR;
                  end
               end
            end
            S_KINST: if (sdi_fire && !kinst_bad) state <= S_KHDR;
            S_KHDR: begin
               if (sdi_fire) begin
                  kcnt  <= KCW'(KW);
                  state <= S_KDATA;
               end
            end
            S_KDATA: begin
               if (sdi_fire) begin
                  kcnt <= kcnt - KCW'(1);
                  if (kcnt == KCW'(1)) state <= S_INST;
               end
            end
            S_HDR: begin
               if (pdi_fire && !hdr_bad) begin
                  bdi_type <= op;
                  flg_eoi  <= pdi_data[HDR_EOI];
                  flg_eot  <= pdi_data[HDR_EOT];
                  flg_last <= pdi_data[HDR_LAST];
                  state    <= (pdi_data[15:0] == 16'd0) ? S_ZERO : S_DATA;
               end
            end
            S_DATA: if (bdi_fire && seg_last) state <= flg_last ? S_INST : S_HDR;
            S_ZERO: if (bdi_fire) state <= flg_last ? S_INST : S_HDR;
            default: state <= S_INST;
         endcase
      end
   end

endmodule
